selector_sequencer: RTL

Upstream stage for the selector-driven register stage: accepts a stream of (selector, repeat-count) commands over a valid/ready handshake, buffers them in a small FIFO, and drives one selector per cycle into the downstream `case` stage. The downstream stage consumes a selector every cycle and never stalls. This block therefore owns all buffering, pacing and range checking of selectors.

---
 rtl/selector_pkg.sv | 25 ++
 rtl/sel_cmd_fifo.sv | 82 ++++++++
 rtl/selector_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/selector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : selector_pkg                                                |
// | Desc   : Shared widths, command struct and issuer state encoding for |
// |          the selector sequencer and the downstream case stage.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package selector_pkg;

   localparam int SEL_W   = 3;
   localparam int CNT_W   = 4;
   localparam int MAX_SEL = 6;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [CNT_W-1:0] count;
   } sel_cmd_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/sel_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sel_cmd_fifo                                                |
// | Desc   : Synchronous DEPTH-entry FIFO holding selector commands.     |
// |          Push is ignored when full, pop is ignored when empty.       |
// | Ports  : clock, reset    - clock / synchronous active-high reset     |
// |          push, wdata     - write request and data                    |
// |          pop, rdata      - read request, head-of-queue data          |
// |          full, empty     - occupancy status                          |
// |          level           - current occupancy (0..DEPTH)              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sel_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 7
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == (PTR_W+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (PTR_W+1)'(1);
         2'b01:   level_d = level_q - (PTR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/selector_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : selector_sequencer                                          |
// | Desc   : Accepts (selector, repeat-count) commands, buffers them and |
// |          issues one selector per cycle to a never-stalling stage.    |
// | Ports  : clock, reset            - clock / sync active-high reset    |
// |          in_valid/in_ready       - command handshake                 |
// |          in_sel, in_count        - selector and repeat count         |
// |          out_valid, out_sel      - registered selector stream        |
// |          err_bad_sel             - sticky out-of-range flag          |
// |          level                   - FIFO occupancy                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module selector_sequencer #(
   parameter int DEPTH   = 4,
   parameter int SEL_W   = selector_pkg::SEL_W,
   parameter int CNT_W   = selector_pkg::CNT_W,
   parameter int MAX_SEL = selector_pkg::MAX_SEL
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [CNT_W-1:0]         in_count,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     err_bad_sel,
   output logic [$clog2(DEPTH):0]   level
);

   import selector_pkg::*;

   localparam logic [SEL_W-1:0] MAX_SEL_C = SEL_W'(MAX_SEL);

   logic                     fifo_full, fifo_empty;
   logic                     transfer, bad_sel, push, pop;
   logic [SEL_W+CNT_W-1:0]   head;
   logic [SEL_W-1:0]         head_sel;
   logic [CNT_W-1:0]         head_count;

   issue_state_e             state_q, state_d;
   logic [CNT_W-1:0]         remaining_q, remaining_d;
   logic                     out_valid_q, out_valid_d;
   logic [SEL_W-1:0]         out_sel_q, out_sel_d;
   logic                     err_q, err_d;

   // Ready looks only at registered occupancy; it is held low during reset
   // so nothing is accepted before the FIFO state is known.
   assign in_ready = !reset && !fifo_full;
   assign transfer = in_valid && in_ready;
   assign bad_sel  = (in_sel > MAX_SEL_C);
   assign push     = transfer && !bad_sel && (in_count != '0);

   assign {head_sel, head_count} = head;

   sel_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (SEL_W + CNT_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata ({in_sel, in_count}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      err_d       = err_q | (transfer & bad_sel);
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               state_d     = ISSUE;
               remaining_d = head_count;
               out_valid_d = 1'b1;
               out_sel_d   = head_sel;
            end
         end
         ISSUE: begin
            if (remaining_q == CNT_W'(1)) begin
               // Last cycle of this command: chain the next one with no
               // bubble when available, otherwise fall back to IDLE.
               if (!fifo_empty) begin
                  pop         = 1'b1;
                  remaining_d = head_count;
                  out_sel_d   = head_sel;
               end else begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  out_sel_d   = '0;
               end
            end else begin
               remaining_d = remaining_q - CNT_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         err_q       <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_sel     = out_sel_q;
   assign err_bad_sel = err_q;

endmodule
`default_nettype wire
